// File: rtl/trng_sample_controller.sv
// TRNG sample controller: warm-up flush, decimated capture into words, a
// valid/ready word output and a sticky repetition-count health test.
// Ports: clk, rst (sync, active-high); start (level run request);
//   sampled_bit (sampler output); sampler_en (sampler enable);
//   word_out / word_valid / word_ready (word handshake);
//   busy (active session); health_fail (sticky health failure).
// Optional macro TRNG_VN_DEBIAS_EN adds von Neumann debiasing of captures.
module trng_sample_controller #(
    parameter int WORD_W        = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int DECIM         = 4,
    parameter int REP_LIMIT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sampled_bit,
    output logic              sampler_en,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              health_fail
);

    localparam int WCW = $clog2(WARMUP_CYCLES + 1);
    localparam int DCW = $clog2(DECIM + 1);
    localparam int BCW = $clog2(WORD_W + 1);
    localparam int RCW = $clog2(REP_LIMIT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WARMUP  = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;

    logic [2:0]        state;
    logic [WCW-1:0]    warm_cnt;
    logic [DCW-1:0]    dec_cnt;
    logic [BCW-1:0]    bit_cnt;
    logic [RCW-1:0]    run_cnt;
    logic              last_bit;
    logic [WORD_W-1:0] shift_reg;

`ifdef TRNG_VN_DEBIAS_EN
    logic              pair_vld;
    logic              pair_bit;
`endif

    logic              cap;
    logic              dec_wrap;
    logic [RCW-1:0]    run_nxt;
    logic              rep_hit;
    logic              emit;
    logic              emit_bit;
    logic              word_done;
    logic [WORD_W-1:0] shift_nxt;

    assign sampler_en  = (state == S_WARMUP) || (state == S_COLLECT);
    assign busy        = (state != S_IDLE) && (state != S_FAIL);
    assign health_fail = (state == S_FAIL);

    always_comb begin
        dec_wrap = (dec_cnt == DCW'(DECIM - 1));
        cap      = (state == S_COLLECT) && start && dec_wrap;
        // A zero run count marks the first capture of a session.
        run_nxt  = RCW'(1);
        if ((run_cnt != '0) && (sampled_bit == last_bit))
            run_nxt = run_cnt + 1'b1;
        rep_hit  = (run_nxt == RCW'(REP_LIMIT));
`ifdef TRNG_VN_DEBIAS_EN
        // Pair 01 emits 0, 10 emits 1: the emitted bit is the first of the pair.
        emit     = cap && pair_vld && (pair_bit != sampled_bit);
        emit_bit = pair_bit;
`else
        emit     = cap;
        emit_bit = sampled_bit;
`endif
        shift_nxt = {shift_reg[WORD_W-2:0], emit_bit};
        word_done = emit && (bit_cnt == BCW'(WORD_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            warm_cnt   <= '0;
            dec_cnt    <= '0;
            bit_cnt    <= '0;
            run_cnt    <= '0;
            last_bit   <= 1'b0;
            shift_reg  <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
            pair_vld   <= 1'b0;
            pair_bit   <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_WARMUP;
                        warm_cnt <= '0;
                    end
                end
                S_WARMUP: begin
                    if (!start) begin
                        state <= S_IDLE;
                    end else if (warm_cnt == WCW'(WARMUP_CYCLES - 1)) begin
                        state     <= S_COLLECT;
                        dec_cnt   <= '0;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        run_cnt   <= '0;
`ifdef TRNG_VN_DEBIAS_EN
                        pair_vld  <= 1'b0;
`endif
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (!start) begin
                        state <= S_IDLE;
                    end else begin
                        dec_cnt <= dec_wrap ? '0 : dec_cnt + 1'b1;
                        if (cap) begin
                            run_cnt  <= run_nxt;
                            last_bit <= sampled_bit;
                            // Health failure wins over word completion.
                            if (rep_hit) begin
                                state <= S_FAIL;
                            end else begin
`ifdef TRNG_VN_DEBIAS_EN
                                pair_vld <= !pair_vld;
                                if (!pair_vld)
                                    pair_bit <= sampled_bit;
`endif
                                if (emit) begin
                                    shift_reg <= shift_nxt;
                                    bit_cnt   <= bit_cnt + 1'b1;
                                end
                                if (word_done) begin
                                    state      <= S_HOLD;
                                    word_out   <= shift_nxt;
                                    word_valid <= 1'b1;
                                    bit_cnt    <= '0;
                                end
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        if (start) begin
                            // Resume capture without re-warm-up; the
                            // run count carries over within the session.
                            state     <= S_COLLECT;
                            dec_cnt   <= '0;
                            bit_cnt   <= '0;
                            shift_reg <= '0;
`ifdef TRNG_VN_DEBIAS_EN
                            pair_vld  <= 1'b0;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_FAIL: begin
                    state <= S_FAIL;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_sample_controller.sv
// Testbench for trng_sample_controller: vector table, directed corner
// sequences and randomized run against a behavioural reference model.
module tb_trng_sample_controller;

    localparam int WW = 8;
    localparam int WU = 4;
    localparam int DC = 2;
    localparam int RL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sampled_bit;
    logic          sampler_en;
    logic [WW-1:0] word_out;
    logic          word_valid;
    logic          word_ready;
    logic          busy;
    logic          health_fail;

    always #5 clk = ~clk;

    trng_sample_controller #(
        .WORD_W(WW),
        .WARMUP_CYCLES(WU),
        .DECIM(DC),
        .REP_LIMIT(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .sampled_bit(sampled_bit),
        .sampler_en(sampler_en),
        .word_out(word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .busy(busy),
        .health_fail(health_fail)
    );

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: session phases with queues of captured bits.
    typedef enum int {M_IDLE, M_WARM, M_COL, M_HOLD, M_FAIL} mode_t;
    mode_t         m_mode;
    int            m_warm;
    int            m_col;
    bit            m_raw[$];
    bit            m_word[$];
    bit            m_pair[$];
    logic [WW-1:0] m_out;

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_warm = 0;
        m_col  = 0;
        m_out  = '0;
        m_raw.delete();
        m_word.delete();
        m_pair.delete();
    endfunction

    function automatic bit rep_hit();
        int n = m_raw.size();
        if (n < RL) return 1'b0;
        for (int i = n - RL; i < n; i++)
            if (m_raw[i] != m_raw[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_step(bit r, bit s, bit b, bit rd);
        if (r) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: if (s) begin
                m_mode = M_WARM;
                m_warm = 0;
            end
            M_WARM: begin
                if (!s) m_mode = M_IDLE;
                else begin
                    m_warm++;
                    if (m_warm == WU) begin
                        m_mode = M_COL;
                        m_col  = 0;
                        m_raw.delete();
                        m_word.delete();
                        m_pair.delete();
                    end
                end
            end
            M_COL: begin
                if (!s) m_mode = M_IDLE;
                else begin
                    m_col++;
                    if (m_col % DC == 0) begin
                        m_raw.push_back(b);
                        if (m_raw.size() > RL) void'(m_raw.pop_front());
                        if (rep_hit()) m_mode = M_FAIL;
                        else begin
`ifdef TRNG_VN_DEBIAS_EN
                            m_pair.push_back(b);
                            if (m_pair.size() == 2) begin
                                if (m_pair[0] != m_pair[1])
                                    m_word.push_back(m_pair[0]);
                                m_pair.delete();
                            end
`else
                            m_word.push_back(b);
`endif
                            if (m_word.size() == WW) begin
                                for (int i = 0; i < WW; i++)
                                    m_out[WW-1-i] = m_word[i];
                                m_word.delete();
                                m_mode = M_HOLD;
                            end
                        end
                    end
                end
            end
            M_HOLD: if (rd) begin
                m_mode = s ? M_COL : M_IDLE;
                m_col  = 0;
                m_word.delete();
                m_pair.delete();
            end
            default: ;
        endcase
    endfunction

    task automatic chk_model();
        logic [WW+3:0] act;
        logic [WW+3:0] exp;
        act = {sampler_en, busy, word_valid, health_fail, word_out};
        exp = {(m_mode == M_WARM) || (m_mode == M_COL),
               (m_mode != M_IDLE) && (m_mode != M_FAIL),
               m_mode == M_HOLD, m_mode == M_FAIL, m_out};
        chk("model", 32'(act), 32'(exp));
    endtask

    task automatic tick(bit r, bit s, bit b, bit rd);
        rst = r;
        start = s;
        sampled_bit = b;
        word_ready = rd;
        model_step(r, s, b, rd);
        @(posedge clk);
        #1;
        if (sampler_en) en_cnt++;
        chk_model();
    endtask

    task automatic open_session();
        en_cnt = 0;
        repeat (WU + 1) tick(0, 1, 0, 0);
    endtask

    task automatic feed(logic [31:0] v, int n);
        for (int i = 0; i < n; i++)
            repeat (DC) tick(0, 1, v[n-1-i], 0);
    endtask

    typedef struct {
        logic [7:0] caps;
        logic [7:0] word;
        logic       valid;
        logic       fail;
        int         en;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{8'b10110010, 8'hB2, 1'b1, 1'b0, 20};
        vecs[1] = '{8'b01010101, 8'h55, 1'b1, 1'b0, 20};
        vecs[2] = '{8'b11101110, 8'hEE, 1'b1, 1'b0, 20};
        vecs[3] = '{8'b00010001, 8'h11, 1'b1, 1'b0, 20};
        vecs[4] = '{8'b11110000, 8'h00, 1'b0, 1'b1, 12};
        vecs[5] = '{8'b10000110, 8'h00, 1'b0, 1'b1, 14};
        vecs[6] = '{8'b01100111, 8'h67, 1'b1, 1'b0, 20};
        vecs[7] = '{8'b00100001, 8'h00, 1'b0, 1'b1, 18};
        vecs[8] = '{8'b10101111, 8'h00, 1'b0, 1'b1, 20};

        rst = 1'b1;
        start = 1'b1;
        sampled_bit = 1'b0;
        word_ready = 1'b0;
        model_reset();

        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        chk("reset", 32'({sampler_en, word_out, word_valid, busy,
                          health_fail}), 32'd0);

`ifndef TRNG_VN_DEBIAS_EN
        for (int v = 0; v < 9; v++) begin
            tick(1, 0, 0, 0);
            open_session();
            feed(32'(vecs[v].caps), WW);
            chk($sformatf("vec%0d_word", v), 32'(word_out), 32'(vecs[v].word));
            chk($sformatf("vec%0d_valid", v), 32'(word_valid), 32'(vecs[v].valid));
            chk($sformatf("vec%0d_fail", v), 32'(health_fail), 32'(vecs[v].fail));
            chk($sformatf("vec%0d_en", v), 32'(en_cnt), 32'(vecs[v].en));
        end

        tick(1, 0, 0, 0);
        open_session();
        feed(32'h0B2, WW);
        for (int i = 0; i < 10; i++) tick(0, i[0], 0, 0);
        chk("bp_word", 32'(word_out), 32'hB2);
        chk("bp_valid", 32'(word_valid), 32'd1);
        chk("bp_en", 32'(sampler_en), 32'd0);
        en_cnt = 0;
        tick(0, 1, 0, 1);
        chk("hs_valid", 32'(word_valid), 32'd0);
        chk("hs_en", 32'(sampler_en), 32'd1);
        feed(32'h04D, WW);
        chk("w2_word", 32'(word_out), 32'h4D);
        chk("w2_valid", 32'(word_valid), 32'd1);
        chk("w2_en", 32'(en_cnt), 32'(WW * DC));
        tick(1, 1, 0, 0);
        chk("rst_hold", 32'({sampler_en, word_out, word_valid, busy,
                             health_fail}), 32'd0);

        tick(1, 0, 0, 0);
        open_session();
        feed(32'h047, WW);
        tick(0, 1, 1, 1);
        feed(32'h1, 1);
        chk("run_carry_fail", 32'(health_fail), 32'd1);
        for (int i = 0; i < 6; i++) tick(0, i[0], 1, 1);
        chk("fail_sticky", 32'({health_fail, busy, word_valid,
                                sampler_en}), 32'h8);
        tick(1, 1, 0, 0);
        chk("fail_clear", 32'(health_fail), 32'd0);

        tick(1, 0, 0, 0);
        open_session();
        feed(32'b10111, 5);
        tick(0, 0, 0, 0);
        chk("abort", 32'({busy, sampler_en, word_valid}), 32'd0);
        open_session();
        feed(32'h0E5, WW);
        chk("restart_word", 32'(word_out), 32'hE5);
        chk("restart_fail", 32'(health_fail), 32'd0);
        chk("restart_en", 32'(en_cnt), 32'd20);
`else
        tick(1, 0, 0, 0);
        open_session();
        feed(32'b0110_1100_1001_1010_0110 >> 1, 19);
        chk("vn_early", 32'(word_valid), 32'd0);
        feed(32'h0, 1);
        chk("vn_valid", 32'(word_valid), 32'd1);
        chk("vn_word", 32'(word_out), 32'h6D);
        chk("vn_en", 32'(en_cnt), 32'd44);
        tick(1, 0, 0, 0);
        open_session();
        feed(32'hF, 4);
        chk("vn_fail", 32'(health_fail), 32'd1);
`endif

        tick(1, 0, 0, 0);
        begin
            bit pb = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                bit r;
                bit s;
                r = ($urandom_range(0, 299) == 0) ||
                    ((m_mode == M_FAIL) && ($urandom_range(0, 7) == 0));
                s = ($urandom_range(0, 99) < 97);
                pb = pb ^ ($urandom_range(0, 99) < 65);
                tick(r, s, pb, 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
